// File: rtl/vend_ctrl.sv
// vend_ctrl: credit-and-dispense controller for a four-product vending machine.
// Optional feature macro: VEND_TIMEOUT_EN (idle auto-refund after TIMEOUT cycles).
module vend_ctrl #(
   parameter int CW         = 4,
   parameter int MAX_CREDIT = 10,
   parameter int PRICE0     = 3,
   parameter int PRICE1     = 2,
   parameter int PRICE2     = 4,
   parameter int PRICE3     = 5,
   parameter int TIMEOUT    = 1000
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          coin1,
   input  logic          coin2,
   input  logic          sel_valid,
   input  logic [1:0]    sel_id,
   input  logic          cancel,
   input  logic          disp_ack,
   output logic          disp_req,
   output logic [1:0]    disp_id,
   output logic          chg_pulse,
   output logic          coin_reject,
   output logic          sel_nak,
   output logic [CW-1:0] credit,
   output logic          busy
);
   typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] credit_q, credit_d, price;
   logic [CW:0]   sum;
   logic          disp_req_q, disp_req_d;
   logic [1:0]    disp_id_q, disp_id_d;
   logic          chg_pulse_q, chg_pulse_d;
   logic          coin_reject_q, coin_reject_d;
   logic          sel_nak_q, sel_nak_d;
`ifdef VEND_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmr_q, tmr_d;
`endif

   if (MAX_CREDIT > (2 ** CW) - 1 || TIMEOUT < 1) begin : g_param_check
      $error("vend_ctrl: MAX_CREDIT does not fit in CW bits or TIMEOUT < 1");
   end

   // price lookup and credit-plus-coins sum (one extra bit to detect overflow)
   always_comb begin
      price = sel_id == 2'd0 ? CW'(PRICE0) :
              sel_id == 2'd1 ? CW'(PRICE1) :
              sel_id == 2'd2 ? CW'(PRICE2) : CW'(PRICE3);
      sum   = {1'b0, credit_q} + {{CW{1'b0}}, coin1} + {{(CW-1){1'b0}}, coin2, 1'b0};
   end

   // next-state and next-output logic; pulse outputs default low every cycle
   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      disp_req_d    = disp_req_q;
      disp_id_d     = disp_id_q;
      chg_pulse_d   = 1'b0;
      coin_reject_d = 1'b0;
      sel_nak_d     = 1'b0;
`ifdef VEND_TIMEOUT_EN
      tmr_d         = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (cancel && credit_q != '0) begin
               state_d       = S_CHANGE;
               coin_reject_d = coin1 | coin2;
            end else if (sel_valid && credit_q >= price) begin
               credit_d      = credit_q - price;
               disp_req_d    = 1'b1;
               disp_id_d     = sel_id;
               state_d       = S_VEND;
               coin_reject_d = coin1 | coin2;
            end else begin
               sel_nak_d = sel_valid;
               if (sum <= (CW+1)'(MAX_CREDIT))
                  credit_d = sum[CW-1:0];
               else
                  coin_reject_d = 1'b1;
`ifdef VEND_TIMEOUT_EN
               if (!(coin1 | coin2 | sel_valid | cancel) && credit_q != '0) begin
                  if (tmr_q == TW'(TIMEOUT - 1))
                     state_d = S_CHANGE;
                  else
                     tmr_d = tmr_q + 1'b1;
               end
`endif
            end
         end
         S_VEND: begin
            coin_reject_d = coin1 | coin2;
            if (disp_ack) begin
               disp_req_d = 1'b0;
               state_d    = credit_q != '0 ? S_CHANGE : S_IDLE;
            end
         end
         S_CHANGE: begin
            coin_reject_d = coin1 | coin2;
            if (chg_pulse_q) begin
               state_d = credit_q == '0 ? S_IDLE : S_CHANGE;
            end else begin
               chg_pulse_d = 1'b1;
               credit_d    = credit_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and registered outputs, cleared by synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         credit_q      <= '0;
         disp_req_q    <= 1'b0;
         disp_id_q     <= 2'd0;
         chg_pulse_q   <= 1'b0;
         coin_reject_q <= 1'b0;
         sel_nak_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         disp_req_q    <= disp_req_d;
         disp_id_q     <= disp_id_d;
         chg_pulse_q   <= chg_pulse_d;
         coin_reject_q <= coin_reject_d;
         sel_nak_q     <= sel_nak_d;
      end
   end

`ifdef VEND_TIMEOUT_EN
   // idle refund counter
   always_ff @(posedge clk) begin
      if (!rstn)
         tmr_q <= '0;
      else
         tmr_q <= tmr_d;
   end
`endif

   assign disp_req    = disp_req_q;
   assign disp_id     = disp_id_q;
   assign chg_pulse   = chg_pulse_q;
   assign coin_reject = coin_reject_q;
   assign sel_nak     = sel_nak_q;
   assign credit      = credit_q;
   assign busy        = state_q != S_IDLE;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed scoreboard bench for vend_ctrl.
module tb_vend_ctrl;
   typedef struct packed {
      logic [3:0] cr;
      logic       dr;
      logic [1:0] di;
      logic       cp;
      logic       rj;
      logic       nk;
      logic       by;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       coin1 = 1'b0, coin2 = 1'b0, sel_valid = 1'b0, cancel = 1'b0, disp_ack = 1'b0;
   logic [1:0] sel_id = 2'd0;
   logic       disp_req, chg_pulse, coin_reject, sel_nak, busy;
   logic [1:0] disp_id;
   logic [3:0] credit;
   exp_t       sb[$];
   int         total = 0;
   int         bad = 0;

   vend_ctrl #(.TIMEOUT(8)) dut (
      .clk(clk), .rstn(rstn), .coin1(coin1), .coin2(coin2), .sel_valid(sel_valid),
      .sel_id(sel_id), .cancel(cancel), .disp_ack(disp_ack), .disp_req(disp_req),
      .disp_id(disp_id), .chg_pulse(chg_pulse), .coin_reject(coin_reject),
      .sel_nak(sel_nak), .credit(credit), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic cyc(input string tag, input logic c1, input logic c2, input logic sv,
                      input logic [1:0] sid, input logic cn, input logic ak, input logic rn,
                      input logic [3:0] cr, input logic dr, input logic [1:0] di,
                      input logic cp, input logic rj, input logic nk, input logic by);
      exp_t got, ex;
      coin1 = c1; coin2 = c2; sel_valid = sv; sel_id = sid; cancel = cn; disp_ack = ak; rstn = rn;
      sb.push_back('{cr, dr, di, cp, rj, nk, by});
      @(posedge clk);
      #1;
      coin1 = 0; coin2 = 0; sel_valid = 0; sel_id = 0; cancel = 0; disp_ack = 0; rstn = 1;
      got = '{credit, disp_req, disp_id, chg_pulse, coin_reject, sel_nak, busy};
      ex = sb.pop_front();
      total++;
      assert (got === ex) else begin
         bad++;
         $error("FAIL %s observed cr=%0d req=%b id=%0d chg=%b rej=%b nak=%b busy=%b expected cr=%0d req=%b id=%0d chg=%b rej=%b nak=%b busy=%b",
                tag, got.cr, got.dr, got.di, got.cp, got.rj, got.nk, got.by,
                ex.cr, ex.dr, ex.di, ex.cp, ex.rj, ex.nk, ex.by);
      end
   endtask

   initial begin
      cyc("rst0",     0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
      cyc("rst1",     0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
      // exact-price purchase, no change
      cyc("t1_c2",    0,1,0,0,0,0,1, 2,0,0,0,0,0,0);
      cyc("t1_c1",    1,0,0,0,0,0,1, 3,0,0,0,0,0,0);
      cyc("t1_sel0",  0,0,1,0,0,0,1, 0,1,0,0,0,0,1);
      cyc("t1_wait",  0,0,0,0,0,0,1, 0,1,0,0,0,0,1);
      cyc("t1_ign",   0,0,1,3,1,0,1, 0,1,0,0,0,0,1);
      cyc("t1_ack",   0,0,0,0,0,1,1, 0,0,0,0,0,0,0);
      cyc("t1_idle",  0,0,0,0,0,0,1, 0,0,0,0,0,0,0);
      // credit ceiling
      for (int i = 1; i <= 5; i++) cyc("t2_fill", 0,1,0,0,0,0,1, 4'(2*i),0,0,0,0,0,0);
      cyc("t2_ovf",   0,1,0,0,0,0,1, 10,0,0,0,1,0,0);
      cyc("t2_hold",  0,0,0,0,0,0,1, 10,0,0,0,0,0,0);
      cyc("t2_rst",   0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
      for (int i = 1; i <= 4; i++) cyc("t2_fill8", 0,1,0,0,0,0,1, 4'(2*i),0,0,0,0,0,0);
      cyc("t2_both",  1,1,0,0,0,0,1, 8,0,0,0,1,0,0);
      cyc("t2_max",   0,1,0,0,0,0,1, 10,0,0,0,0,0,0);
      // refused selection, then purchase with change
      cyc("t3_rst",   0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
      cyc("t3_c2",    0,1,0,0,0,0,1, 2,0,0,0,0,0,0);
      cyc("t3_nak",   0,0,1,2,0,0,1, 2,0,0,0,0,1,0);
      cyc("t3_nakc",  0,1,1,2,0,0,1, 4,0,0,0,0,1,0);
      cyc("t3_c1",    1,0,0,0,0,0,1, 5,0,0,0,0,0,0);
      cyc("t3_sel1",  0,0,1,1,0,0,1, 3,1,1,0,0,0,1);
      cyc("t3_vcoin", 1,0,0,0,0,0,1, 3,1,1,0,1,0,1);
      cyc("t3_ack",   0,0,0,0,0,1,1, 3,0,1,0,0,0,1);
      cyc("t3_p1",    0,0,0,0,0,0,1, 2,0,1,1,0,0,1);
      cyc("t3_g1",    0,0,0,0,0,0,1, 2,0,1,0,0,0,1);
      cyc("t3_p2",    0,0,0,0,0,0,1, 1,0,1,1,0,0,1);
      cyc("t3_g2",    0,0,0,0,0,0,1, 1,0,1,0,0,0,1);
      cyc("t3_p3",    0,0,0,0,0,0,1, 0,0,1,1,0,0,1);
      cyc("t3_idle",  0,0,0,0,0,0,1, 0,0,1,0,0,0,0);
      cyc("t3_ackid", 0,0,0,0,0,1,1, 0,0,1,0,0,0,0);
      // cancel beats selection, coin rejected during change
      cyc("t4_c2a",   0,1,0,0,0,0,1, 2,0,1,0,0,0,0);
      cyc("t4_c2b",   0,1,0,0,0,0,1, 4,0,1,0,0,0,0);
      cyc("t4_cansel",0,0,1,1,1,0,1, 4,0,1,0,0,0,1);
      cyc("t4_p1",    0,0,0,0,0,0,1, 3,0,1,1,0,0,1);
      cyc("t4_g1",    0,0,0,0,0,0,1, 3,0,1,0,0,0,1);
      cyc("t4_p2",    0,0,0,0,0,0,1, 2,0,1,1,0,0,1);
      cyc("t4_g2rej", 1,0,0,0,0,0,1, 2,0,1,0,1,0,1);
      cyc("t4_p3",    0,0,0,0,0,0,1, 1,0,1,1,0,0,1);
      cyc("t4_g3",    0,0,0,0,0,0,1, 1,0,1,0,0,0,1);
      cyc("t4_p4",    0,0,0,0,0,0,1, 0,0,1,1,0,0,1);
      cyc("t4_idle",  0,0,0,0,0,0,1, 0,0,1,0,0,0,0);
      cyc("t4_can0",  0,0,0,0,1,0,1, 0,0,1,0,0,0,0);
      cyc("t4_nak0",  0,0,1,0,0,0,1, 0,0,1,0,0,1,0);
      // reset abandons VEND and CHANGE
      cyc("t5_c2",    0,1,0,0,0,0,1, 2,0,1,0,0,0,0);
      cyc("t5_c1",    1,0,0,0,0,0,1, 3,0,1,0,0,0,0);
      cyc("t5_sel1",  0,0,1,1,0,0,1, 1,1,1,0,0,0,1);
      cyc("t5_rstv",  0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
      cyc("t5_idle",  0,0,0,0,0,0,1, 0,0,0,0,0,0,0);
      cyc("t5_c2b",   0,1,0,0,0,0,1, 2,0,0,0,0,0,0);
      cyc("t5_can",   0,0,0,0,1,0,1, 2,0,0,0,0,0,1);
      cyc("t5_p1",    0,0,0,0,0,0,1, 1,0,0,1,0,0,1);
      cyc("t5_rstc",  0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
      cyc("t5_idle2", 0,0,0,0,0,0,1, 0,0,0,0,0,0,0);
`ifdef VEND_TIMEOUT_EN
      // idle timeout refund, restarted by a coin
      cyc("t6_c2",    0,1,0,0,0,0,1, 2,0,0,0,0,0,0);
      cyc("t6_c1",    1,0,0,0,0,0,1, 3,0,0,0,0,0,0);
      for (int i = 0; i < 6; i++) cyc("t6_wait", 0,0,0,0,0,0,1, 3,0,0,0,0,0,0);
      cyc("t6_c1b",   1,0,0,0,0,0,1, 4,0,0,0,0,0,0);
      for (int i = 0; i < 7; i++) cyc("t6_wait2", 0,0,0,0,0,0,1, 4,0,0,0,0,0,0);
      cyc("t6_tmo",   0,0,0,0,0,0,1, 4,0,0,0,0,0,1);
      for (int i = 3; i >= 0; i--) begin
         cyc("t6_p",  0,0,0,0,0,0,1, 4'(i),0,0,1,0,0,1);
         if (i > 0) cyc("t6_g", 0,0,0,0,0,0,1, 4'(i),0,0,0,0,0,1);
      end
      cyc("t6_idle",  0,0,0,0,0,0,1, 0,0,0,0,0,0,0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Credit-and-dispense controller for a four-product vending machine. It accumulates coin credit, arbitrates product selection against per-product prices, and sequences a dispense handshake with the mechanism. It then returns leftover credit as serial change pulses. It sits between the coin acceptor/keypad front end and the dispenser/change hopper.

## Interface
Parameters:
- `CW`, 4: credit register width, in half-yuan units.
- `MAX_CREDIT`, 10: maximum credit that can be held. Must be ≤ 2^CW−1.
- `PRICE0`, 3: product 0 price, in units.
- `PRICE1`, 2: product 1 price.
- `PRICE2`, 4: product 2 price.
- `PRICE3`, 5: product 3 price.
- `TIMEOUT`, 1000: idle cycles before auto-refund. Used only with `VEND_TIMEOUT_EN`.

Ports (clock and reset first):
- `clk`, in, 1: the only clock. Rising edge.
- `rstn`, in, 1: reset. Synchronous and active-low.
- `coin1`, in, 1: one-cycle pulse, a 0.5 yuan coin (+1 unit).
- `coin2`, in, 1: one-cycle pulse, a 1 yuan coin (+2 units).
- `sel_valid`, in, 1: one-cycle selection strobe.
- `sel_id`, in, 2: selected product. Sampled when `sel_valid` is high.
- `cancel`, in, 1: one-cycle refund request.
- `disp_ack`, in, 1: dispenser done. One-cycle pulse.
- `disp_req`, out, 1: dispense request. Level output, held until ack.
- `disp_id`, out, 2: product to dispense. Stable while `disp_req` is high.
- `chg_pulse`, out, 1: eject one 0.5 yuan coin. One-cycle pulse.
- `coin_reject`, out, 1: one-cycle pulse; the coin(s) from the previous cycle were returned.
- `sel_nak`, out, 1: one-cycle pulse; the previous selection was refused.
- `credit`, out, CW: current credit.
- `busy`, out, 1: high when the state is not IDLE.

## Operation
- States are IDLE, VEND and CHANGE. Reset (`rstn`=0 at an edge, from any state) forces IDLE with credit=0. All outputs are 0 after reset. A reset during VEND or CHANGE abandons that operation.
- Coins in IDLE, when no selection is accepted in the same cycle:
  - Compute sum = coin1·1 + coin2·2.
  - If credit+sum ≤ MAX_CREDIT, add the sum to credit.
  - Otherwise leave credit unchanged and pulse `coin_reject`. Both coins are rejected together.
- Coins arriving in VEND or CHANGE are always rejected with `coin_reject`.
- Priority in IDLE, highest first: cancel, then selection, then coins.
- Cancel in IDLE:
  - With credit>0, go to CHANGE. Any coins in the same cycle are rejected.
  - With credit=0, cancel is ignored.
- Selection in IDLE, with price p = PRICE[sel_id]:
  - Compare p against the credit held before this cycle's coins are added.
  - If credit ≥ p: credit←credit−p, `disp_req`←1, `disp_id`←sel_id, go to VEND. Any coins in the same cycle are rejected.
  - If credit < p: pulse `sel_nak`, stay in IDLE, and process coins normally.
- VEND:
  - Hold `disp_req` and `disp_id` until `disp_ack`.
  - On ack, drop `disp_req` at the next edge. Go to CHANGE if credit>0, otherwise go to IDLE.
  - `sel_valid` and `cancel` are ignored.
- CHANGE:
  - `chg_pulse` is high on alternate cycles, starting the first cycle after entry (pattern 1,0,1,0…).
  - Credit decrements by 1 in each pulse cycle.
  - After the pulse that brings credit to 0, go to IDLE. The next cycle is IDLE.
  - `sel_valid` and `cancel` are ignored.
- `disp_ack` outside VEND is ignored.

## Timing
- All outputs are registered. Each takes effect in the cycle after the causing input edge.
- Coin to credit update: 1 cycle.
- Selection to `disp_req`: 1 cycle.
- `disp_ack` to `disp_req` low: 1 cycle. The CHANGE or IDLE transition happens on the same edge.
- Change for N units: the first pulse comes 1 cycle after entering CHANGE. N pulses span 2N−1 cycles. IDLE follows the last pulse by 1 cycle.
- Credit arithmetic is unsigned CW-bit and can never underflow, because the price check precedes subtraction.
- Credit never exceeds MAX_CREDIT; the reject path guarantees this.

## Configuration
- Macro: `VEND_TIMEOUT_EN`.
- When defined:
  - A counter runs in IDLE while credit>0. It clears on any coin, sel_valid or cancel, and on leaving IDLE.
  - When the counter reaches TIMEOUT, go to CHANGE and refund everything, exactly as a cancel would.
  - When credit=0, the counter is held at 0.
- When undefined: there is no counter and no counter logic. Credit is held in IDLE indefinitely.

## Test plan
- coin2, then coin1 (credit 3), then sel_valid with sel_id=0 → `disp_req`=1 with `disp_id`=0 and credit 0. `disp_ack` → IDLE with no `chg_pulse`.
- Credit 10, then coin2 → `coin_reject` pulse and credit stays 10. Then coin1 and coin2 together with credit 8 → both rejected and credit 8.
- Credit 2, sel_id=2 (price 4) → `sel_nak` and credit 2. Credit 5, sel_id=1 → dispense, ack, then 3 `chg_pulse` on alternate cycles and credit counting 3→0.
- Credit 4, cancel and sel_valid in the same cycle → CHANGE with 4 pulses and no `disp_req`. A coin during CHANGE → `coin_reject`.
- Assert `rstn`=0 mid-VEND and mid-CHANGE → next cycle IDLE, credit 0, all outputs 0.
- With `VEND_TIMEOUT_EN` and TIMEOUT=8: credit 3, then no activity → CHANGE after 8 idle cycles and 3 pulses. A coin at idle cycle 7 restarts the count.
